// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: tracks header/payload/parity
// progress and FIFO status, and emits Moore strobes for router_reg and FIFO writes.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] addr_reg, addr_next;
  logic [1:0] sel_addr;
  logic       sel_empty;
  logic       sel_soft_reset;

  // While decoding, the header byte itself picks the FIFO; afterwards the latched address does.
  assign sel_addr = (state_reg == DECODE_ADDRESS) ? data_in : addr_reg;

  always_comb begin
    sel_empty      = 1'b0;
    sel_soft_reset = 1'b0;
    case (sel_addr)
      2'd0: begin
        sel_empty      = fifo_empty_0;
        sel_soft_reset = soft_reset_0;
      end
      2'd1: begin
        sel_empty      = fifo_empty_1;
        sel_soft_reset = soft_reset_1;
      end
      2'd2: begin
        sel_empty      = fifo_empty_2;
        sel_soft_reset = soft_reset_2;
      end
      default: begin
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg <= DECODE_ADDRESS;
      addr_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    if (state_reg != DECODE_ADDRESS && sel_soft_reset) begin
      state_next = DECODE_ADDRESS;
    end else begin
      case (state_reg)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            addr_next = data_in;
            if (data_in != 2'd3)
              state_next = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          // A full FIFO stalls the packet even when pkt_valid has already dropped.
          if (fifo_full)       state_next = FIFO_FULL_STATE;
          else if (!pkt_valid) state_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_next = DECODE_ADDRESS;
          else if (low_pkt_valid) state_next = LOAD_PARITY;
          else                    state_next = LOAD_DATA;
        end
        LOAD_PARITY:        state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (sel_empty) state_next = LOAD_FIRST_DATA;
        end
        default: state_next = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_add    = (state_reg == DECODE_ADDRESS);
  assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
  assign ld_state      = (state_reg == LOAD_DATA);
  assign laf_state     = (state_reg == LOAD_AFTER_FULL);
  assign full_state    = (state_reg == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
  assign write_enb_reg = ld_state | laf_state | (state_reg == LOAD_PARITY);
  assign busy          = ~(detect_add | ld_state);

endmodule
